// File: rtl/keypad_entry.sv
// keypad_entry: scans a 4x4 active-low matrix keypad, debounces presses and
// releases, and reports one hex code per press with a single-cycle strobe.
// Optional digit entry is built when KEYPAD_DIGIT_ENTRY_EN is defined; the
// newest decimal digit lands in num0 and C clears all four. Without the
// macro, num0..num3 are tied to zero.
module keypad_entry #(
    parameter int unsigned SCAN_DIV = 50000,
    parameter int unsigned DEBOUNCE = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] row,
    output logic [3:0] col,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic [3:0] num0,
    output logic [3:0] num1,
    output logic [3:0] num2,
    output logic [3:0] num3
);

    localparam int unsigned SLOT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(SCAN_DIV - 1);
    localparam logic [3:0] DB_TARGET = 4'(DEBOUNCE);

    typedef enum logic [1:0] {
        ST_SCAN,
        ST_DEBOUNCE,
        ST_PRESSED,
        ST_RELEASE
    } state_t;

    logic [1:0]        rst_sync;
    logic              rst_i;
    logic [3:0]        row_meta;
    logic [3:0]        row_s;
    logic [SLOT_W-1:0] slot;
    logic              sample;
    state_t            state;
    logic [1:0]        c;
    logic [1:0]        c_inc;
    logic [3:0]        col_inc;
    logic [3:0]        cnt;
    logic [3:0]        cnt_inc;
    logic [3:0]        pat;
    logic [3:0]        key_next;

    // Hex code for the lowest active row of a captured pattern in column cc.
    function automatic logic [3:0] key_lookup(input logic [3:0] p, input logic [1:0] cc);
        logic [1:0] r;
        logic [3:0] k;
        r = 2'd3;
        if (!p[0])      r = 2'd0;
        else if (!p[1]) r = 2'd1;
        else if (!p[2]) r = 2'd2;
        case ({r, cc})
            4'b00_00: k = 4'h1;
            4'b00_01: k = 4'h2;
            4'b00_10: k = 4'h3;
            4'b00_11: k = 4'hA;
            4'b01_00: k = 4'h4;
            4'b01_01: k = 4'h5;
            4'b01_10: k = 4'h6;
            4'b01_11: k = 4'hB;
            4'b10_00: k = 4'h7;
            4'b10_01: k = 4'h8;
            4'b10_10: k = 4'h9;
            4'b10_11: k = 4'hC;
            4'b11_00: k = 4'h0;
            4'b11_01: k = 4'hF;
            4'b11_10: k = 4'hE;
            default:  k = 4'hD;
        endcase
        return k;
    endfunction

    // Reset asserts asynchronously and releases two clocks later.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rst_sync <= 2'b00;
        else        rst_sync <= {rst_sync[0], 1'b1};
    end
    assign rst_i = rst_sync[1];

    // Two-flop synchronizer for the asynchronous row inputs.
    always_ff @(posedge clk or negedge rst_i) begin
        if (!rst_i) begin
            row_meta <= 4'hF;
            row_s    <= 4'hF;
        end else begin
            row_meta <= row;
            row_s    <= row_meta;
        end
    end

    assign sample   = (slot == SLOT_LAST);
    assign c_inc    = c + 2'd1;
    assign col_inc  = ~(4'b0001 << c_inc);
    assign cnt_inc  = cnt + 4'd1;
    assign key_next = key_lookup(pat, c);

    // Slot timer, column rotation and press/release debounce state machine.
    always_ff @(posedge clk or negedge rst_i) begin
        if (!rst_i) begin
            state     <= ST_SCAN;
            slot      <= '0;
            c         <= 2'd0;
            col       <= 4'b1110;
            cnt       <= 4'd0;
            pat       <= 4'hF;
            key_code  <= 4'h0;
            key_valid <= 1'b0;
        end else begin
            key_valid <= 1'b0;
            slot      <= sample ? '0 : slot + SLOT_W'(1);
            case (state)
                ST_SCAN: begin
                    if (sample) begin
                        if (row_s == 4'hF) begin
                            c   <= c_inc;
                            col <= col_inc;
                        end else begin
                            pat   <= row_s;
                            cnt   <= 4'd1;
                            state <= (DEBOUNCE == 1) ? ST_PRESSED : ST_DEBOUNCE;
                        end
                    end
                end
                ST_DEBOUNCE: begin
                    if (sample) begin
                        if (row_s == pat) begin
                            cnt <= cnt_inc;
                            if (cnt_inc == DB_TARGET) state <= ST_PRESSED;
                        end else begin
                            cnt   <= 4'd0;
                            c     <= c_inc;
                            col   <= col_inc;
                            state <= ST_SCAN;
                        end
                    end
                end
                ST_PRESSED: begin
                    key_code  <= key_next;
                    key_valid <= 1'b1;
                    cnt       <= 4'd0;
                    state     <= ST_RELEASE;
                end
                ST_RELEASE: begin
                    if (sample) begin
                        if (row_s == 4'hF) begin
                            if (cnt_inc == DB_TARGET) begin
                                cnt   <= 4'd0;
                                c     <= c_inc;
                                col   <= col_inc;
                                state <= ST_SCAN;
                            end else begin
                                cnt <= cnt_inc;
                            end
                        end else begin
                            cnt <= 4'd0;
                        end
                    end
                end
            endcase
        end
    end

`ifdef KEYPAD_DIGIT_ENTRY_EN
    // Decimal keys shift in as the newest digit; C clears the entry.
    always_ff @(posedge clk or negedge rst_i) begin
        if (!rst_i) begin
            num0 <= 4'h0;
            num1 <= 4'h0;
            num2 <= 4'h0;
            num3 <= 4'h0;
        end else if (state == ST_PRESSED) begin
            if (key_next <= 4'h9) begin
                num3 <= num2;
                num2 <= num1;
                num1 <= num0;
                num0 <= key_next;
            end else if (key_next == 4'hC) begin
                num0 <= 4'h0;
                num1 <= 4'h0;
                num2 <= 4'h0;
                num3 <= 4'h0;
            end
        end
    end
`else
    assign num0 = 4'h0;
    assign num1 = 4'h0;
    assign num2 = 4'h0;
    assign num3 = 4'h0;
`endif

endmodule

// File: tb/tb_keypad_entry.sv
// Bench for keypad_entry: a physical keypad model closes switches between the
// driven column and the rows; expected codes and digits come from a
// row-major key table and a digit list.
module tb_keypad_entry;

    localparam int unsigned SD = 4;
    localparam int unsigned DB = 3;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] row;
    logic [3:0] col;
    logic [3:0] key_code;
    logic       key_valid;
    logic [3:0] num0, num1, num2, num3;

    logic [15:0] pressed = 16'h0;
    logic [3:0]  keys_tab [16];
    logic [3:0]  dig [4];
    int          checks = 0;
    int          errors = 0;
    int          vcount = 0;

    keypad_entry #(.SCAN_DIV(SD), .DEBOUNCE(DB)) dut (
        .clk(clk), .rst_n(rst_n), .row(row), .col(col),
        .key_code(key_code), .key_valid(key_valid),
        .num0(num0), .num1(num1), .num2(num2), .num3(num3)
    );

    always #5 clk = ~clk;

    // Keypad switch matrix: a closed key pulls its row low while its column is driven.
    always_comb begin
        logic [3:0] r_tmp;
        r_tmp = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int cc = 0; cc < 4; cc++)
                if (pressed[r*4+cc] && (col[cc] == 1'b0)) r_tmp[r] = 1'b0;
        row = r_tmp;
    end

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Strobe counter and column legality monitor.
    always @(negedge clk) begin
        if (key_valid === 1'b1) vcount++;
        check("col_onehot", 16'($onehot(~col)), 16'd1);
    end

    function automatic int find_key(input logic [3:0] k);
        for (int i = 0; i < 16; i++) if (keys_tab[i] == k) return i;
        return 0;
    endfunction

    task automatic model_key(input logic [3:0] k);
        if (k <= 4'h9) begin
            dig[3] = dig[2]; dig[2] = dig[1]; dig[1] = dig[0]; dig[0] = k;
        end else if (k == 4'hC) begin
            for (int i = 0; i < 4; i++) dig[i] = 4'h0;
        end
    endtask

    task automatic check_nums(input string tag);
`ifdef KEYPAD_DIGIT_ENTRY_EN
        check(tag, {num3, num2, num1, num0}, {dig[3], dig[2], dig[1], dig[0]});
`else
        check(tag, {num3, num2, num1, num0}, 16'h0000);
`endif
    endtask

    // Close the keys in mask, expect one strobe with exp_code, hold, release.
    task automatic press_keys(input logic [15:0] mask, input logic [3:0] exp_code, input int hold);
        int v0;
        int n;
        v0 = vcount;
        n = 0;
        pressed = mask;
        while (key_valid !== 1'b1 && n < 48) begin
            @(negedge clk);
            n++;
        end
        check("press_latency_ok", 16'(n < 48), 16'd1);
        check("key_code", 16'(key_code), 16'(exp_code));
        model_key(exp_code);
        check_nums("nums_at_strobe");
        repeat (hold) @(negedge clk);
        pressed = 16'h0;
        repeat (24) @(negedge clk);
        check("strobes_per_press", 16'(vcount - v0), 16'd1);
        check("key_code_hold", 16'(key_code), 16'(exp_code));
        check_nums("nums_hold");
    endtask

    task automatic press_key(input logic [3:0] k, input int hold);
        press_keys(16'h1 << find_key(k), k, hold);
    endtask

    // Wait until the scan freshly enters the given column pattern.
    task automatic wait_col_entry(input logic [3:0] target);
        int n;
        n = 0;
        while (col === target && n < 40) begin @(negedge clk); n++; end
        while (col !== target && n < 40) begin @(negedge clk); n++; end
        check("wait_col", 16'(col), 16'(target));
    endtask

    initial begin
        logic [3:0] prev;
        int last_chg;
        int changes;
        int v0;

        keys_tab = '{4'h1, 4'h2, 4'h3, 4'hA,
                     4'h4, 4'h5, 4'h6, 4'hB,
                     4'h7, 4'h8, 4'h9, 4'hC,
                     4'h0, 4'hF, 4'hE, 4'hD};
        for (int i = 0; i < 4; i++) dig[i] = 4'h0;

        // Reset state
        repeat (5) @(negedge clk);
        check("rst_col", 16'(col), 16'h000E);
        check("rst_key_code", 16'(key_code), 16'h0);
        check("rst_key_valid", 16'(key_valid), 16'h0);
        check_nums("rst_nums");
        rst_n = 1'b1;

        // Idle rotation with all rows high
        prev = col;
        last_chg = -1;
        changes = 0;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            if (col !== prev) begin
                check("rot_next", 16'(col), 16'({prev[2:0], prev[3]}));
                if (last_chg >= 0) check("rot_period", 16'(i - last_chg), 16'(SD));
                last_chg = i;
                changes++;
                prev = col;
            end
        end
        check("rot_changes_ok", 16'(changes >= 14), 16'd1);
        check("idle_no_strobe", 16'(vcount), 16'd0);

        // Single press r1/c2
        press_key(4'h6, 5);

        // One-sample bounce on r2 in column 0
        v0 = vcount;
        wait_col_entry(4'b1110);
        pressed = 16'h1 << 8;
        repeat (4) @(negedge clk);
        pressed = 16'h0;
        repeat (4) @(negedge clk);
        check("bounce_advance_col", 16'(col), 16'h000D);
        repeat (20) @(negedge clk);
        check("bounce_no_strobe", 16'(vcount - v0), 16'd0);

        // Digit entry sequence
        press_key(4'h2, 2);
        press_key(4'h0, 0);
        press_key(4'h2, 7);
        press_key(4'h1, 3);
        press_key(4'h9, 1);
`ifdef KEYPAD_DIGIT_ENTRY_EN
        check("digits_0219", {num3, num2, num1, num0}, 16'h0219);
`endif
        press_key(4'hC, 2);
        check("digits_cleared", {num3, num2, num1, num0}, 16'h0000);
        press_key(4'h7, 1);
        press_key(4'hA, 4);

        // Two rows held in column 3: the lower row index wins, no repeat
        press_keys((16'h1 << 3) | (16'h1 << 15), 4'hA, 100);

        // Randomized presses
        for (int i = 0; i < 15; i++) press_key(4'($urandom_range(0, 15)), int'($urandom_range(0, 20)));

        // Asynchronous reset in the middle of a debounce
        v0 = vcount;
        wait_col_entry(4'b1101);
        pressed = 16'h1 << 1;
        repeat (6) @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("async_rst_col", 16'(col), 16'h000E);
        check("async_rst_key_code", 16'(key_code), 16'h0);
        for (int i = 0; i < 4; i++) dig[i] = 4'h0;
        check_nums("async_rst_nums");
        pressed = 16'h0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (30) @(negedge clk);
        check("async_rst_no_strobe", 16'(vcount - v0), 16'd0);

        // Recovery after reset
        press_key(4'h5, 3);
        press_key(4'hD, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
